sr_latch_driver: RTL and testbench



---
 rtl/sr_latch_driver.sv | 137 +++++++++++++
 tb/tb_sr_latch_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Control stage for a gated NAND SR latch: converts single-cycle set/clear
// requests into held, mutually exclusive S/R pulses and confirms the result.
module sr_latch_driver #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 8
) (
    input  logic clk,
    input  logic rstN,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    input  logic qn_fb,
    output logic S,
    output logic R,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   hold_q;
    logic [TW-1:0]   tmo_q;
    logic            target_q;
    logic            q_meta_q;
    logic            q_s_q;
    logic            qn_meta_q;
    logic            qn_s_q;
    logic            s_q;
    logic            r_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    // A latch that shows Q==QN is in a forbidden/transient state and is never confirmed.
    function automatic logic fb_match(input logic q, input logic qn, input logic tgt);
        return (q == tgt) && (qn == ~tgt) && (q != qn);
    endfunction

    // Feedback synchronizers plus the request/drive/settle controller.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            tmo_q     <= '0;
            target_q  <= 1'b0;
            q_meta_q  <= 1'b0;
            q_s_q     <= 1'b0;
            qn_meta_q <= 1'b0;
            qn_s_q    <= 1'b0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            q_meta_q  <= q_fb;
            q_s_q     <= q_meta_q;
            qn_meta_q <= qn_fb;
            qn_s_q    <= qn_meta_q;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (set_req && !clr_req) begin
                        target_q <= 1'b1;
                        s_q      <= 1'b1;
                        r_q      <= 1'b0;
                        hold_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= DRIVE;
                    end else if (clr_req && !set_req) begin
                        target_q <= 1'b0;
                        s_q      <= 1'b0;
                        r_q      <= 1'b1;
                        hold_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= DRIVE;
                    end else if (set_req && clr_req) begin
                        err_q    <= 1'b1;
                        s_q      <= 1'b0;
                        r_q      <= 1'b0;
                    end else begin
                        s_q      <= 1'b0;
                        r_q      <= 1'b0;
                    end
                end
                DRIVE: begin
                    // Drive ends on the edge after the last held cycle.
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= SETTLE;
                    end else begin
                        hold_q  <= hold_q + HW'(1);
                    end
                end
                SETTLE: begin
                    if (fb_match(q_s_q, qn_s_q, target_q)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q   <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural latch in the loop, a timeline-based
// reference model of the driver, directed scenarios and a randomized run.
module tb_sr_latch_driver;

    localparam int H = 2;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_fb;
    logic qn_fb;
    logic S, R, busy, done, err;

    // Behavioural latch and an override used to fake a stuck latch.
    logic lat_q = 1'b0;
    logic lat_qn = 1'b1;
    logic frc_en = 1'b0;
    logic frc_q = 1'b0;
    logic frc_qn = 1'b0;

    assign q_fb  = frc_en ? frc_q  : lat_q;
    assign qn_fb = frc_en ? frc_qn : lat_qn;

    sr_latch_driver #(.HOLD_CYCLES(H), .TIMEOUT(T)) dut (
        .clk(clk), .rstN(rstN), .set_req(set_req), .clr_req(clr_req),
        .q_fb(q_fb), .qn_fb(qn_fb),
        .S(S), .R(R), .busy(busy), .done(done), .err(err)
    );

    always #20 clk = ~clk;

    // NAND latch: two gate delays to the leading output, one more to the other.
    always @(S or R) begin
        if (S && !R) begin
            #16 lat_q = 1'b1;
            #8  lat_qn = 1'b0;
        end else if (R && !S) begin
            #16 lat_qn = 1'b1;
            #8  lat_q = 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: an operation is described by its start edge and direction.
    int   n = 0;
    int   k = 0;
    bit   op = 1'b0;
    bit   dir = 1'b0;
    bit   e_S, e_R, e_busy, e_done, e_err;
    bit   rst_prev = 1'b1;
    logic [1:0] fb_prev1 = 2'b00;
    logic [1:0] fb_prev2 = 2'b00;
    int   last_done = -1;
    int   last_err = -1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    // One clock edge: advance the model, then compare every output against it.
    task automatic tick();
        logic sq, sqn;
        int d;
        @(posedge clk);
        n++;
        sq  = rst_prev ? 1'b0 : fb_prev2[1];
        sqn = rst_prev ? 1'b0 : fb_prev2[0];
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!rstN) begin
            op = 1'b0;
        end else if (!op) begin
            if (set_req != clr_req) begin
                op  = 1'b1;
                k   = n;
                dir = set_req;
            end else if (set_req && clr_req) begin
                e_err = 1'b1;
            end
        end else begin
            d = n - k;
            if (d >= H + 1) begin
                if (sq == dir && sqn == !dir) begin
                    e_done = 1'b1;
                    op = 1'b0;
                end else if (d == H + T) begin
                    e_err = 1'b1;
                    op = 1'b0;
                end
            end
        end
        fb_prev2 = fb_prev1;
        fb_prev1 = rstN ? {q_fb, qn_fb} : 2'b00;
        rst_prev = !rstN;
        e_S    = op && dir  && ((n - k) < H);
        e_R    = op && !dir && ((n - k) < H);
        e_busy = op;
        #1;
        check_bit("S", S, e_S);
        check_bit("R", R, e_R);
        check_bit("busy", busy, e_busy);
        check_bit("done", done, e_done);
        check_bit("err", err, e_err);
        check_bit("s_r_exclusive", S && R, 1'b0);
        if (done === 1'b1) last_done = n;
        if (err === 1'b1) last_err = n;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && busy !== 1'b0; i++) tick();
        check_bit("idle_within_bound", busy, 1'b0);
    endtask

    int kreq;

    initial begin
        // Reset state
        rstN = 1'b0;
        tick();
        tick();
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_S", S, 1'b0);
        rstN = 1'b1;
        tick();

        // Reset while driving S drops it at the same edge
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        check_bit("drive_started_S", S, 1'b1);
        rstN = 1'b0;
        tick();
        check_bit("reset_mid_drive_S", S, 1'b0);
        check_bit("reset_mid_drive_busy", busy, 1'b0);
        rstN = 1'b1;
        tick();

        // Set: done three edges after the request edge
        set_req = 1'b1;
        tick();
        kreq = n;
        set_req = 1'b0;
        wait_idle();
        check_int("set_done_latency", last_done - kreq, 3);
        check_bit("set_q_fb", q_fb, 1'b1);
        check_bit("set_qn_fb", qn_fb, 1'b0);

        // Clear from Q=1
        clr_req = 1'b1;
        tick();
        kreq = n;
        clr_req = 1'b0;
        wait_idle();
        check_int("clr_done_latency", last_done - kreq, 3);
        check_bit("clr_q_fb", q_fb, 1'b0);

        // Conflicting request
        set_req = 1'b1;
        clr_req = 1'b1;
        tick();
        set_req = 1'b0;
        clr_req = 1'b0;
        check_bit("conflict_err", err, 1'b1);
        check_bit("conflict_busy", busy, 1'b0);
        tick();
        check_bit("conflict_err_pulse", err, 1'b0);

        // Timeout with a latch stuck at Q=0
        frc_en = 1'b1;
        frc_q = 1'b0;
        frc_qn = 1'b1;
        set_req = 1'b1;
        tick();
        kreq = n;
        set_req = 1'b0;
        wait_idle();
        check_int("timeout_err_latency", last_err - kreq, 10);
        check_bit("timeout_no_done", (last_done > kreq) ? 1'b1 : 1'b0, 1'b0);
        frc_en = 1'b0;
        repeat (3) tick();

        // Clear request while busy is ignored
        set_req = 1'b1;
        tick();
        kreq = n;
        set_req = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_idle();
        check_int("busy_ignore_done_latency", last_done - kreq, 3);
        repeat (3) tick();
        check_bit("busy_ignore_no_second_op", busy, 1'b0);

        // Randomized traffic, occasional resets and stuck-latch episodes
        for (int i = 0; i < 3000; i++) begin
            rstN    = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            set_req = ($urandom_range(0, 3) == 0);
            clr_req = ($urandom_range(0, 3) == 0);
            if (busy === 1'b0 && $urandom_range(0, 19) == 0) begin
                frc_en = ($urandom_range(0, 3) == 0);
                frc_q  = $urandom_range(0, 1) == 1;
                frc_qn = $urandom_range(0, 1) == 1;
            end
            tick();
        end
        rstN = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        frc_en = 1'b0;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
